// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl
//   Raster-scan sequencer for the LBP engine. Walks every interior center
//   (1..IMG_W-2, 1..IMG_H-2), issues gray memory reads into the 3x3 window
//   held by the compare datapath, then strobes one LBP write per center.
//   Border pixels are never written.
//
// Optional feature (build macro LBP_COL_REUSE_EN):
//   When defined, centers after the first in a row shift the window one
//   column left and fetch only the new right-hand column (3 reads).
//   When undefined, every center fetches a full 9-read window and
//   win_shift_o is tied low.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   gray_ready_i   gray memory available; low stalls the fetch in place
//   gray_req_o     gray memory read request (data valid at closing edge)
//   gray_addr_o    read address {y,x}
//   win_load_o     datapath captures gray data into slot win_slot_o
//   win_slot_o     window slot 3*(dy+1)+(dx+1), 0..8
//   win_shift_o    datapath shifts window one column left
//   lbp_addr_o     address {y,x} of the current center
//   lbp_valid_o    LBP memory write strobe
//   finish_o       scan complete, held until reset
//
// State   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for gray_ready_i, all outputs low
// S_FETCH | issuing window reads for center (x_q,y_q), col_q/row_q index
// S_WRITE | one-cycle LBP write for the current center, then advance
// S_DONE  | last center written, finish_o high until reset
module lbp_scan_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          gray_ready_i,
  output logic          gray_req_o,
  output logic [AW-1:0] gray_addr_o,
  output logic          win_load_o,
  output logic [3:0]    win_slot_o,
  output logic          win_shift_o,
  output logic [AW-1:0] lbp_addr_o,
  output logic          lbp_valid_o,
  output logic          finish_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = AW - XW;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    col_q, col_d;   // window column 0..2 (dx+1)
  logic [1:0]    row_q, row_d;   // window row 0..2 (dy+1)
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  // Neighbor coordinates; never wrap because centers are interior only.
  assign nx = x_q + XW'(col_q) - XW'(1);
  assign ny = y_q + YW'(row_q) - YW'(1);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    row_d       = row_q;
    gray_req_o  = 1'b0;
    gray_addr_o = '0;
    win_load_o  = 1'b0;
    win_slot_o  = '0;
    win_shift_o = 1'b0;
    lbp_addr_o  = '0;
    lbp_valid_o = 1'b0;
    finish_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gray_ready_i) begin
          state_d = S_FETCH;
          x_d     = XW'(1);
          y_d     = YW'(1);
          col_d   = 2'd0;
          row_d   = 2'd0;
        end
      end

      S_FETCH: begin
        // A stall simply withholds the request; counters hold so the same
        // read reissues when memory comes back.
        if (gray_ready_i) begin
          gray_req_o  = 1'b1;
          win_load_o  = 1'b1;
          gray_addr_o = {ny, nx};
          win_slot_o  = {2'b00, row_q} * 4'd3 + {2'b00, col_q};
          // Column-major walk: rows within a column, then next column.
          if (row_q == 2'd2) begin
            row_d = 2'd0;
            if (col_q == 2'd2) state_d = S_WRITE;
            else               col_d   = col_q + 2'd1;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        lbp_valid_o = 1'b1;
        lbp_addr_o  = {y_q, x_q};
        if (x_q != X_LAST) begin
          state_d = S_FETCH;
          x_d     = x_q + XW'(1);
`ifdef LBP_COL_REUSE_EN
          // Old columns slide left; only the new right column is fetched.
          win_shift_o = 1'b1;
          col_d       = 2'd2;
`else
          col_d       = 2'd0;
`endif
        end else if (y_q != Y_LAST) begin
          state_d = S_FETCH;
          x_d     = XW'(1);
          y_d     = y_q + YW'(1);
          col_d   = 2'd0;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        finish_o = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl on a reduced 16x12 image so that full scans fit
// comfortably in either build. A center-level reference model predicts
// every cycle's outputs; a small window model checks that the loaded
// window matches the image neighbourhood at each write.
module tb_lbp_scan_ctrl;

  localparam int W     = 16;
  localparam int H     = 12;
  localparam int AW    = 8;
  localparam int NCENT = (W - 2) * (H - 2);
  localparam int LAST_ADDR = (H - 2) * W + (W - 2);
`ifdef LBP_COL_REUSE_EN
  localparam bit REUSE    = 1'b1;
  localparam int SCAN_CYC = (H - 2) * (10 + (W - 3) * 4);
`else
  localparam bit REUSE    = 1'b0;
  localparam int SCAN_CYC = NCENT * 10;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          win_load;
  logic [3:0]    win_slot;
  logic          win_shift;
  logic [AW-1:0] lbp_addr;
  logic          lbp_valid;
  logic          finish;

  always #5 clk = ~clk;

  lbp_scan_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) u_dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .gray_ready_i (gray_ready),
    .gray_req_o   (gray_req),
    .gray_addr_o  (gray_addr),
    .win_load_o   (win_load),
    .win_slot_o   (win_slot),
    .win_shift_o  (win_shift),
    .lbp_addr_o   (lbp_addr),
    .lbp_valid_o  (lbp_valid),
    .finish_o     (finish)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which center, which read within it, which mode.
  typedef enum {M_IDLE, M_SCAN, M_DONE} mmode_e;
  mmode_e m_mode = M_IDLE;
  int     m_cx, m_cy, m_k;
  bit     m_part;

  int win [9];
  bit written [W*H];
  int n_writes, cyc, t_first, t_last;
  bit seen_req;

  function automatic int pix(input int a);
    return ((a * 73) ^ (a >> 3)) & 255;
  endfunction

  function automatic void m_update(input bit rst, input bit rdy);
    if (rst) begin
      m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: if (rdy) begin
        m_mode = M_SCAN; m_cx = 1; m_cy = 1; m_k = 0; m_part = 1'b0;
      end
      M_SCAN: begin
        if (m_k < (m_part ? 3 : 9)) begin
          if (rdy) m_k++;
        end else if (m_cx < W - 2) begin
          m_cx++; m_k = 0; m_part = REUSE;
        end else if (m_cy < H - 2) begin
          m_cx = 1; m_cy++; m_k = 0; m_part = 1'b0;
        end else begin
          m_mode = M_DONE;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic step(input bit rst, input bit rdy, input bit do_chk);
    int dx, dy, e_addr, e_slot, e_laddr, a;
    bit e_req, e_shift, e_valid, e_fin;
    e_req = 0; e_shift = 0; e_valid = 0; e_fin = 0;
    e_addr = 0; e_slot = 0; e_laddr = 0;
    @(negedge clk);
    reset = rst;
    gray_ready = rdy;
    #1;
    if (m_mode == M_SCAN) begin
      if (m_k < (m_part ? 3 : 9)) begin
        e_req = rdy;
        if (m_part) begin dx = 1; dy = m_k - 1; end
        else begin dx = m_k / 3 - 1; dy = m_k % 3 - 1; end
        e_slot = 3 * (dy + 1) + (dx + 1);
        e_addr = (m_cy + dy) * W + m_cx + dx;
      end else begin
        e_valid = 1;
        e_laddr = m_cy * W + m_cx;
        e_shift = REUSE && (m_cx < W - 2);
      end
    end else if (m_mode == M_DONE) begin
      e_fin = 1;
    end

    if (do_chk) begin
      chk("ctl{req,load,shift,valid,finish}",
          {gray_req, win_load, win_shift, lbp_valid, finish},
          {e_req, e_req, e_shift, e_valid, e_fin});
      if (m_mode != M_SCAN) begin
        chk("quiet_gray_addr", gray_addr, 0);
        chk("quiet_slot", win_slot, 0);
        chk("quiet_lbp_addr", lbp_addr, 0);
      end else if (e_req) begin
        chk("rd_addr", gray_addr, e_addr);
        chk("rd_slot", win_slot, e_slot);
      end else if (e_valid) begin
        chk("wr_addr", lbp_addr, e_laddr);
        for (int s = 0; s < 9; s++)
          chk("window", win[s], pix((m_cy + s / 3 - 1) * W + m_cx + s % 3 - 1));
      end
      if (gray_req === 1'b1 && !seen_req) begin
        seen_req = 1;
        t_first = cyc;
      end
      if (lbp_valid === 1'b1) begin
        a = int'(lbp_addr);
        n_writes++;
        chk("border_write", (a % W == 0) || (a % W == W - 1) || (a / W == 0) || (a / W >= H - 1), 0);
        if (a < W * H) begin
          chk("dup_write", written[a], 0);
          written[a] = 1;
        end
        if (a == LAST_ADDR) t_last = cyc;
      end
    end

    // Datapath window model driven by the controller's strobes.
    if (win_shift === 1'b1)
      for (int r = 0; r < 3; r++) begin
        win[3*r]   = win[3*r+1];
        win[3*r+1] = win[3*r+2];
      end
    if (win_load === 1'b1 && win_slot < 9) win[win_slot] = pix(int'(gray_addr));

    @(posedge clk);
    m_update(rst, rdy);
    cyc++;
  endtask

  task automatic clear_book();
    foreach (written[i]) written[i] = 0;
    n_writes = 0; seen_req = 0; t_first = -1; t_last = -1;
  endtask

  task automatic run_scan(input int stall_pct, input int reset_center, input int stall5_center);
    int  ci, stall_left;
    bit  rdy, rst, rst_done, s5_done, done_seen;
    stall_left = 0; rst_done = 0; s5_done = 0; done_seen = 0;
    clear_book();
    for (int i = 0; i < 3 * SCAN_CYC + 200; i++) begin
      ci  = (m_cy - 1) * (W - 2) + (m_cx - 1);
      rst = 0;
      if (stall_left > 0) begin
        rdy = 0; stall_left--;
      end else if (m_mode == M_SCAN && !s5_done && ci == stall5_center && m_k == 4 && !m_part) begin
        rdy = 0; stall_left = 4; s5_done = 1;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      if (m_mode == M_SCAN && !rst_done && ci == reset_center && m_k == 2) begin
        rst = 1; rst_done = 1;
      end
      step(rst, rdy, 1);
      if (rst) clear_book();
      if (m_mode == M_DONE) begin
        done_seen = 1;
        break;
      end
    end
    // finish must hold regardless of gray_ready
    for (int i = 0; i < 4; i++) step(0, 1'($urandom_range(1)), 1);
    chk("finish_held", finish, 1);
    chk("write_count", n_writes, NCENT);
    if (stall_pct == 0 && reset_center < 0 && stall5_center < 0)
      chk("scan_cycles", t_last - t_first + 1, SCAN_CYC);
    if (!done_seen) chk("scan_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    gray_ready = 1'b0;
    foreach (win[i]) win[i] = 0;
    cyc = 0;
    clear_book();
    m_mode = M_IDLE;
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Stall-free scan, cycle count checked against the closed form.
    run_scan(0, -1, -1);

    // Random stalls plus a 5-cycle drop on the 5th read of a row-start window.
    step(1, 0, 1);
    step(1, 0, 1);
    run_scan(15, -1, W - 2);

    // Reset in the middle of a scan, then completion after restart.
    step(1, 0, 1);
    run_scan(10, 50, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lbp_scan_ctrl.md
# lbp_scan_ctrl

Sequencing controller for the LBP engine. It scans the 128×128 grayscale image in raster order over interior centers (1..126, 1..126) and drives gray memory reads into a 3×3 window register held in the separate LBP compare datapath. It issues one `lbp_valid` write per center and raises `finish` after the last center. Border pixels are never written; the LBP memory pre-clears them to 0.

## Interface
- `IMG_W`, default 128: image width; must be a power of two.
- `IMG_H`, default 128: image height.
- `AW`, default 14: address width, equal to log2(IMG_W*IMG_H).
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `gray_ready`  in  1: gray memory is available; scanning may proceed.
- `gray_req`  out  1: read request. `gray_data` for `gray_addr` is valid at the closing edge of the same cycle.
- `gray_addr`  out  AW: pixel address = y*IMG_W + x.
- `win_load`  out  1: datapath captures `gray_data` into slot `win_slot` at this edge. Always equals `gray_req`.
- `win_slot`  out  4: window slot index = 3*(dy+1) + (dx+1), range 0..8.
- `win_shift`  out  1: datapath shifts the window one column left at this edge (col1→col0, col2→col1).
- `lbp_addr`  out  AW: address of the current center.
- `lbp_valid`  out  1: write strobe. The datapath drives `lbp_data` combinationally from the window.
- `finish`  out  1: scan complete; stays high until reset.

## Operation
- States are IDLE, FETCH, WRITE and DONE.
- IDLE: all outputs are low. If `gray_ready` is sampled 1, go to FETCH with the center at (x=1, y=1) and load a full window.
- FETCH, full window: 9 reads, column-major. Columns go x-1, x, x+1; within each column, rows go y-1, y, y+1. Slots are issued in the order 0,3,6,1,4,7,2,5,8.
- FETCH, partial window: 3 reads of column x+1, rows y-1..y+1, into slots 2, 5, 8.
- FETCH stall: if `gray_ready`=0, drive `gray_req`=0 and `win_load`=0 and freeze all counters. Resume the same read when `gray_ready` returns to 1.
- WRITE lasts one cycle: `lbp_valid`=1 and `lbp_addr`={y,x}. Then advance:
  - x<IMG_W-2: x+1. Next fetch is partial (reuse enabled) or full (reuse disabled).
  - x=IMG_W-2 and y<IMG_H-2: x=1, y+1. Next fetch is a full window.
  - x=IMG_W-2 and y=IMG_H-2: go to DONE.
- `win_shift`=1 only in a WRITE cycle whose next fetch is partial.
- DONE: `finish`=1. All other outputs are low. Exit only via reset.
- Arithmetic: x and y are log2(IMG_W)- and log2(IMG_H)-bit counters. The address is the concatenation {y,x}; no multiplier. Neighbor coordinates are never out of range because centers are interior only.

## Timing
- Reset values: `gray_req`=0, `gray_addr`=0, `win_load`=0, `win_slot`=0, `win_shift`=0, `lbp_valid`=0, `lbp_addr`=0, `finish`=0. State is IDLE.
- Reset asserted mid-scan: outputs take their reset values at the next edge. The scan restarts from (1,1) after the next `gray_ready`.
- First `gray_req` is driven in the cycle after `gray_ready` is first sampled high in IDLE.
- Each center costs 9+1 cycles (full window) or 3+1 cycles (partial window), plus stall cycles.
- `lbp_valid` follows the final window load by exactly 1 cycle.
- `finish` rises in the cycle after the last `lbp_valid` (`lbp_addr`=126*128+126=16254).
- Total writes: (IMG_W-2)*(IMG_H-2) = 15876. No address is written twice.

## Configuration
- `LBP_COL_REUSE_EN` defined:
  - The first center of each row fetches a full window (9 reads).
  - Later centers in the row use `win_shift` and fetch 3 reads.
  - Stall-free total: 126*(10+125*4) = 64260 cycles from first `gray_req` to the last `lbp_valid`, inclusive.
- Undefined:
  - Every center fetches a full window; `win_shift` is tied to 0.
  - Total: 15876*10 = 158760 cycles.
- Outputs written to LBP memory are identical in both builds.

## Test plan
- Reset 2 cycles, then `gray_ready`=1 → first `gray_req` has `gray_addr`=0 with `win_slot`=0. The 9th read is addr 258 with slot 8. Next cycle: `lbp_valid`=1, `lbp_addr`=129.
- With `LBP_COL_REUSE_EN`: the WRITE for center 129 has `win_shift`=1. The next 3 reads are addrs 3, 131, 259 into slots 2, 5, 8; the following `lbp_valid` has `lbp_addr`=130.
- Full pattern with the golden image → 15876 writes, no writes to border addresses (e.g. 0, 127, 16383), and zero mismatches. `finish` appears at the cycle count given above.
- Drop `gray_ready` for 5 cycles during the 5th read of a window → `gray_req` is 0 for those 5 cycles. The same addr and slot reissue on resume. Final image still matches the golden image.
- Assert `reset` mid-row (center 1000) → all outputs are 0 the next cycle. After `gray_ready`, the scan restarts at `gray_addr`=0 and still completes correctly.
- Row wrap: after `lbp_addr`=254 (x=126, y=1), `win_shift`=0 and the next 9 reads start at addr 128. The next write is `lbp_addr`=257.
